// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// stream framing constants and the header legality check.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    LOAD  = 3'd2,
    FLUSH = 3'd3,
    RUN   = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Word count must be nonzero and fit the memory; compared at 32 bits so no truncation.
  function automatic logic hdr_bad(input logic [15:0] n, input int addr_w);
    return (n == 16'd0) || (32'(n) > (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// 8->32 little-endian word assembler; word_valid pulses in the cycle the
// fourth byte of a word is presented, with the completed word alongside.
module byte_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        byte_en,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_p0;
  logic [23:0] shreg_p0;

  // Earlier bytes shift down so the first byte of a word ends in bits [7:0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_p0   <= 2'd0;
      shreg_p0 <= 24'd0;
    end else if (byte_en) begin
      cnt_p0   <= cnt_p0 + 2'd1;
      shreg_p0 <= {in_byte, shreg_p0[23:8]};
    end
  end

  assign word       = {in_byte, shreg_p0};
  assign word_valid = byte_en && (cnt_p0 == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a word-count header, streams words into instruction
// memory, then releases the core from reset.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        s_byte,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              err
);

  state_t state, state_d;

  logic              acc;
  logic [7:0]        n_lo;
  logic [15:0]       n_q;
  logic [ADDR_W:0]   wcnt;
  logic [31:0]       word;
  logic              word_valid;
  logic              last_word;

  assign acc       = s_valid & s_ready;
  assign last_word = (32'(wcnt) + 32'd1) == 32'(n_q);

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .in_byte    (s_byte),
    .byte_en    (acc && (state == LOAD)),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d = state;
    case (state)
      HDR0:    if (acc) state_d = HDR1;
      HDR1:    if (acc) state_d = hdr_bad({s_byte, n_lo}, ADDR_W) ? ERR : LOAD;
      LOAD:    if (word_valid && last_word) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HDR0;
    else        state <= state_d;
  end

  // Status outputs follow the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ready    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      core_reset <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      n_lo       <= 8'd0;
      n_q        <= 16'd0;
      wcnt       <= '0;
    end else begin
      s_ready    <= (state_d == HDR0) || (state_d == HDR1) || (state_d == LOAD);
      core_reset <= (state_d == RUN);
      done       <= (state_d == RUN);
      err        <= (state_d == ERR);
      imem_we    <= word_valid;
      if (acc && (state == HDR0)) n_lo <= s_byte;
      if (acc && (state == HDR1)) n_q  <= {s_byte, n_lo};
      if (word_valid) begin
        imem_addr  <= wcnt[ADDR_W-1:0];
        imem_wdata <= word;
        wcnt       <= wcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: header handling, word packing,
// write strobes, core release timing and reset behaviour.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  s_byte = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [9:0]  waddr_q[$];
  logic [31:0] wdata_q[$];
  int          wcyc_q[$];
  int          done_cyc = -1;

  imem_boot_loader #(.ADDR_W(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_byte     (s_byte),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      waddr_q.push_back(imem_addr);
      wdata_q.push_back(imem_wdata);
      wcyc_q.push_back(cyc);
    end
    if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    waddr_q.delete();
    wdata_q.delete();
    wcyc_q.delete();
    done_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    s_valid = 1'b0;
    #1;
    chk("rst_async_core_reset", core_reset, 0);
    chk("rst_async_done", done, 0);
    chk("rst_async_we", imem_we, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_err", err, 0);
    clear_log();
    reset = 1'b1;
    #1;
    chk("rel_s_ready_before_edge", s_ready, 0);
    @(negedge clk);
    chk("rel_s_ready_after_edge", s_ready, 1);
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int k = 0;
    s_byte  = b;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) begin
      tests++;
      fails++;
      $error("FAIL ready_timeout: got s_ready=%b expected 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap);
  endtask

  task automatic run_two_words(input bit gap, input string pfx);
    send(8'h02, gap);
    send(8'h00, gap);
    send_word(32'h00500013, gap);
    send_word(32'h00A00893, gap);
    // Without gaps we sit right after the last byte edge; with gaps one cycle later.
    if (!gap) begin
      chk({pfx, "_we_last"}, imem_we, 1);
      chk({pfx, "_ready_flush"}, s_ready, 0);
      chk({pfx, "_done_flush"}, done, 0);
      @(negedge clk);
    end
    chk({pfx, "_done"}, done, 1);
    chk({pfx, "_core_reset"}, core_reset, 1);
    chk({pfx, "_we_idle"}, imem_we, 0);
    chk({pfx, "_ready_run"}, s_ready, 0);
    repeat (3) @(negedge clk);
    chk({pfx, "_nwrites"}, waddr_q.size(), 2);
    if (waddr_q.size() == 2) begin
      chk({pfx, "_addr0"}, waddr_q[0], 0);
      chk({pfx, "_data0"}, wdata_q[0], 32'h00500013);
      chk({pfx, "_addr1"}, waddr_q[1], 1);
      chk({pfx, "_data1"}, wdata_q[1], 32'h00A00893);
      chk({pfx, "_release_timing"}, done_cyc, wcyc_q[1] + 1);
    end
  endtask

  initial begin
    int bad;

    do_reset();
    chk("init_core_reset", core_reset, 0);
    chk("init_done", done, 0);

    run_two_words(1'b0, "b2b");

    do_reset();
    run_two_words(1'b1, "gap");

    do_reset();
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    chk("n0_err", err, 1);
    chk("n0_ready", s_ready, 0);
    repeat (4) @(negedge clk);
    chk("n0_err_sticky", err, 1);
    chk("n0_core_reset", core_reset, 0);
    chk("n0_nwrites", waddr_q.size(), 0);

    do_reset();
    send(8'h01, 1'b0);
    send(8'h04, 1'b0);
    chk("n1025_err", err, 1);
    chk("n1025_ready", s_ready, 0);
    chk("n1025_core_reset", core_reset, 0);

    do_reset();
    send(8'h00, 1'b0);
    send(8'h04, 1'b0);
    chk("n1024_no_err", err, 0);
    for (int i = 0; i < 1024; i++) send_word(32'hC0DE0000 | 32'(i), 1'b0);
    repeat (2) @(negedge clk);
    chk("n1024_done", done, 1);
    chk("n1024_nwrites", waddr_q.size(), 1024);
    if (waddr_q.size() == 1024) begin
      bad = 0;
      for (int i = 0; i < 1024; i++)
        if (waddr_q[i] !== 10'(i) || wdata_q[i] !== (32'hC0DE0000 | 32'(i))) bad++;
      chk("n1024_seq", bad, 0);
      chk("n1024_last_addr", waddr_q[1023], 1023);
      chk("n1024_last_data", wdata_q[1023], 32'hC0DE03FF);
    end

    do_reset();
    send(8'h03, 1'b0);
    send(8'h00, 1'b0);
    send_word(32'h11223344, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    @(negedge clk);
    chk("mid_nwrites", waddr_q.size(), 1);
    do_reset();
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    repeat (2) @(negedge clk);
    chk("reload_nwrites", waddr_q.size(), 1);
    if (waddr_q.size() == 1) begin
      chk("reload_addr", waddr_q[0], 0);
      chk("reload_data", wdata_q[0], 32'hDEADBEEF);
    end
    chk("reload_done", done, 1);
    chk("reload_core_reset", core_reset, 1);

    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-stream program loader that writes the instruction memory of `TOP_RISC` and then releases the core from reset. It consumes a little-endian header and instruction stream over a valid/ready byte interface, and packs bytes into 32-bit words. It drives the instruction-memory write port while holding the core in reset, then releases it. It sits between the bench/host byte source and the instruction-memory write port.

## Interface
Parameters:
- `ADDR_W`, default 10: instruction-memory word-address width; depth = 2^ADDR_W words.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s_byte`  in  8  stream byte.
- `s_valid`  in  1  `s_byte` valid.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  instruction word.
- `core_reset`  out  1  active-low reset to the core; 0 holds `TOP_RISC` in reset.
- `done`  out  1  load complete, core running.
- `err`  out  1  illegal header, sticky until `reset`.

## Operation
- Stream format: 2-byte word count N (low byte first), then 4N bytes. Each word is little-endian: stream byte k of a word maps to `imem_wdata[8k+7:8k]`.
- A byte is accepted on a rising edge with `s_valid & s_ready`; `s_byte` is ignored otherwise.
- States:
  - HDR0: accept count low byte, then go to HDR1.
  - HDR1: accept count high byte. If N==0 or N>2^ADDR_W, go to ERR; otherwise go to LOAD.
  - LOAD: accept bytes. On the 4th byte of each word, write it. On the 4th byte of word N-1, go to FLUSH.
  - FLUSH: one cycle, then go to RUN.
  - RUN: terminal; `core_reset`=1 and `done`=1.
  - ERR: terminal; `err`=1 and `core_reset` stays 0.
- `s_ready`=1 in HDR0, HDR1 and LOAD; 0 in FLUSH, RUN and ERR. Back-to-back bytes are accepted every cycle.
- Counters:
  - Byte-in-word counter: 2 bits, wraps 3→0.
  - Word counter: ADDR_W+1 bits, starts at 0, increments after each write.
  - `imem_addr` = word counter value at write time, so addresses run 0..N-1.
- Header check compares the 16-bit N against 2^ADDR_W as an unsigned value at ADDR_W+1 bits or wider; no truncation.
- Reset outputs: `s_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_reset`=0, `done`=0, `err`=0, state HDR0. `s_ready` rises on the first edge after `reset` deasserts.
- Reset mid-load: asynchronous return to HDR0. Partial words and counts are discarded, and the core is re-held in reset immediately.
- Reloading a running core requires asserting `reset`; there is no other restart.

## Timing
- The 4th byte of a word is accepted at edge t. During cycle t..t+1: `imem_we`=1, with `imem_addr` and `imem_wdata` valid and registered. `imem_we` returns to 0 at t+1 unless another word completes.
- Last word accepted at edge t: FLUSH during t..t+1. At edge t+1, `core_reset` and `done` go to 1, so the core leaves reset one cycle after the final write strobe.
- Bad header byte accepted at edge t: `err`=1 and `s_ready`=0 from edge t.
- Minimum load time for N words = 2 + 4N accepted bytes + 1 cycle.
- `s_valid` gaps stall the FSM with no state change. Outputs other than `imem_we` hold their values.

## Structure
- Shared package/header holds:
  - state encodings (HDR0, HDR1, LOAD, FLUSH, RUN, ERR);
  - header length constant (2);
  - bytes-per-word constant (4).
- Natural sub-module `byte_word_packer`: 8→32 little-endian shift/assemble with a 2-bit counter. It outputs `word_valid` for one cycle; the top FSM owns addressing, header checks and core reset.

## Test plan
- Reset (`reset`=0 for 2 cycles) → all outputs 0; after release `s_ready`=1, state HDR0.
- N=2, bytes 13 00 50 00 then 93 08 A0 00 with `s_valid` held → writes addr 0 = 0x00500013 and addr 1 = 0x00A00893, each `imem_we` one cycle. `core_reset`/`done` rise one cycle after the second strobe; `s_ready`=0 thereafter.
- Same stream with `s_valid` toggling every other cycle → identical writes and data; `imem_we` never asserted for a stalled partial word.
- Header 00 00 → `err`=1, `s_ready`=0, `core_reset` stays 0, no `imem_we`. With ADDR_W=10, header 01 04 (N=1025) → `err`=1; header 00 04 (N=1024) → accepted, last write at addr 1023.
- Assert `reset` after 2 bytes of word 1 of an N=3 load → `core_reset`=0 immediately. A fresh N=1 load then writes addr 0 with correct data, with no leftover bytes.
